// File: rtl/adc_frame_capture.sv
// adc_frame_capture
// Receive-side ADC frame grabber. Registers the offset-binary ADC bus and
// converts it to two's complement. After an armed trigger it stores up to
// 2^ADDR_W samples in a synchronous RAM, then streams the frame out on a
// valid/ready port. The port uses an output register plus one skid entry.

module adc_frame_capture #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ad_in,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [ADDR_W-1:0] cap_len,
  output logic              busy,
  output logic              overrange,
  output logic              done,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_READOUT = 2'd3;

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] RAW_MIN = '0;
  localparam logic [DATA_W-1:0] RAW_MAX = '1;

  // Control state
  logic [1:0]               state;
  logic signed [DATA_W-1:0] level_q;
  logic [ADDR_W-1:0]        len_q;
  logic                     mode_q;
  // Counts ARMED cycles (saturates at 2). It qualifies s_prev for the
  // crossing detector, and it times the immediate trigger.
  logic [1:0]               arm_age;
  logic [ADDR_W-1:0]        wr_addr;

  // Input stage
  logic signed [DATA_W-1:0] s;
  logic signed [DATA_W-1:0] s_prev;
  logic                     s_ovr;

  // Frame buffer and read side
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DATA_W-1:0]        rd_data;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     rd_all;
  logic                     rd_pending;
  logic                     rd_pending_last;
  logic                     skid_valid;
  logic                     skid_last;
  logic [DATA_W-1:0]        skid_data;

  // Combinational decode
  logic                     arm_ok;
  logic                     crossing;
  logic                     trigger;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr_cur;
  logic                     wr_final;
  logic                     fire;
  logic                     last_fire;
  logic [1:0]               occupancy;
  logic                     rd_en;

  assign busy = (state != ST_IDLE);

  assign arm_ok   = (state == ST_IDLE) && arm && !abort;
  // Rising crossing uses a signed compare. The first s after arming cannot
  // qualify, because its s_prev was captured before ARMED.
  assign crossing = (s_prev < level_q) && (s >= level_q);
  // Immediate mode fires on the third ARMED cycle. The first stored sample
  // is then the ad_in value presented two cycles after the arm cycle.
  assign trigger  = (state == ST_ARMED) && !abort &&
                    (mode_q ? (arm_age == 2'd2) : ((arm_age != 2'd0) && crossing));

  // The triggering sample goes to address 0. CAPTURE continues from wr_addr.
  assign wr_en       = !rst && (trigger || ((state == ST_CAPTURE) && !abort));
  assign wr_addr_cur = trigger ? '0 : wr_addr;
  assign wr_final    = wr_en && (wr_addr_cur == len_q);

  assign fire      = out_valid && out_ready;
  assign last_fire = (state == ST_READOUT) && !abort && fire && out_last;

  // Entries still held after this edge: output register, skid entry and any
  // read in flight, minus the beat leaving now. A new read is issued only
  // when its data is sure to find a free slot, even if the port stalls.
  assign occupancy = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pending) - 2'(fire);
  assign rd_en     = (state == ST_READOUT) && !abort && !rd_all && (occupancy < 2'd2);

  // Input stage: register the pin, flip the MSB (offset binary -> signed), keep history
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <=. All registers then
    // update together at the edge, whatever order the statements are in.
    if (rst) begin
      s      <= '0;
      s_prev <= '0;
      s_ovr  <= 1'b0;
    end else begin
      s      <= {~ad_in[DATA_W-1], ad_in[DATA_W-2:0]};
      s_prev <= s;
      s_ovr  <= (ad_in == RAW_MIN) || (ad_in == RAW_MAX);
    end
  end

  // Main state machine: arming, trigger qualification and write addressing
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      level_q <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      arm_age <= 2'd0;
      wr_addr <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            level_q <= $signed(trig_level);
            len_q   <= cap_len;
            mode_q  <= trig_mode;
            arm_age <= 2'd0;
            state   <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (trigger) begin
            wr_addr <= ADDR_W'(1);
            state   <= (len_q == '0) ? ST_READOUT : ST_CAPTURE;
          end else if (arm_age != 2'd2) begin
            arm_age <= arm_age + 2'd1;
          end
        end
        ST_CAPTURE: begin
          if (wr_final) begin
            state <= ST_READOUT;
          end else begin
            wr_addr <= wr_addr + ADDR_W'(1);
          end
        end
        ST_READOUT: begin
          if (last_fire) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overrange: set by a railed raw sample entering the frame, cleared on accepted arm
  always_ff @(posedge clk) begin
    if (rst) begin
      overrange <= 1'b0;
    end else if (arm_ok) begin
      overrange <= 1'b0;
    end else if (wr_en && s_ovr) begin
      overrange <= 1'b1;
    end
  end

  // Frame buffer: one write port, one registered read port
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset. Reset and abort leave its contents alone,
    // so it maps onto plain block RAM.
    if (wr_en) begin
      mem[wr_addr_cur] <= s;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

  // Read issue: walk addresses 0..len_q once per frame. Stop at len_q, never wrap.
  always_ff @(posedge clk) begin
    if (rst || abort || (state != ST_READOUT)) begin
      rd_addr         <= '0;
      rd_all          <= 1'b0;
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
    end else begin
      rd_pending      <= rd_en;
      rd_pending_last <= rd_en && (rd_addr == len_q);
      if (rd_en) begin
        if (rd_addr == len_q) begin
          rd_all <= 1'b1;
        end else begin
          rd_addr <= rd_addr + ADDR_W'(1);
        end
      end
    end
  end

  // Output register plus skid entry. Held data stays put until it transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
    end else if (abort || (state != ST_READOUT)) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_last   <= skid_last;
        skid_valid <= rd_pending;
        skid_data  <= rd_data;
        skid_last  <= rd_pending_last;
      end else if (rd_pending) begin
        out_valid <= 1'b1;
        out_data  <= rd_data;
        out_last  <= rd_pending_last;
      end else begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end else if (rd_pending) begin
      skid_valid <= 1'b1;
      skid_data  <= rd_data;
      skid_last  <= rd_pending_last;
    end
  end

  // Completion pulse, one cycle after the final beat transfers
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= last_fire;
    end
  end

endmodule

// File: tb/tb_adc_frame_capture.sv
// tb_adc_frame_capture
// Directed bench for adc_frame_capture. A table of immediate-trigger frames
// is applied in a loop. Hand-written sequences cover threshold triggering,
// abort, reset mid-frame and arm while busy.

module tb_adc_frame_capture;

  localparam int          DATA_W = 12;
  localparam int          ADDR_W = 11;
  localparam logic [11:0] JUNK   = 12'h5A5;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] ad_in;
  logic              arm;
  logic              abort;
  logic              trig_mode;
  logic [DATA_W-1:0] trig_level;
  logic [ADDR_W-1:0] cap_len;
  logic              busy;
  logic              overrange;
  logic              done;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  int n_pass  = 0;
  int n_total = 0;

  logic [11:0] exp_data [2048];

  typedef struct {
    string       name;
    logic [10:0] cap;
    logic [11:0] base;
    int          ready_mode;
    logic [11:0] exp_first;
    logic [11:0] exp_last;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs [6];

  adc_frame_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ad_in      (ad_in),
    .arm        (arm),
    .abort      (abort),
    .trig_mode  (trig_mode),
    .trig_level (trig_level),
    .cap_len    (cap_len),
    .busy       (busy),
    .overrange  (overrange),
    .done       (done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic [10:0] cap, input logic [11:0] base,
                              input int ready_mode, input logic [11:0] exp_first,
                              input logic [11:0] exp_last, input logic exp_ovr);
    vec_t v;
    v.name       = name;
    v.cap        = cap;
    v.base       = base;
    v.ready_mode = ready_mode;
    v.exp_first  = exp_first;
    v.exp_last   = exp_last;
    v.exp_ovr    = exp_ovr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Immediate-trigger arm. The ramp starts two cycles after the arm cycle.
  task automatic drive_mode1(input logic [10:0] cap, input logic [11:0] base);
    @(negedge clk);
    arm        = 1'b1;
    trig_mode  = 1'b1;
    trig_level = 12'h000;
    cap_len    = cap;
    ad_in      = JUNK;
    @(negedge clk);
    arm   = 1'b0;
    ad_in = JUNK;
    check("busy after arm", busy, 1);
    check("overrange cleared by arm", overrange, 0);
    for (int i = 0; i <= int'(cap); i++) begin
      @(negedge clk);
      ad_in = base + 12'(i);
    end
    @(negedge clk);
    ad_in = JUNK;
  endtask

  // Drain n beats against exp_data. ready_mode 0: always ready. 1: 1,0,0,1 repeating.
  task automatic collect(input string name, input int n, input int ready_mode,
                         output logic [11:0] first_d, output logic [11:0] last_d);
    int          beat;
    int          cyc;
    int          budget;
    int          early_done;
    logic        stalled;
    logic [11:0] held_d;
    logic        held_l;
    beat       = 0;
    cyc        = 0;
    budget     = n * 4 + 50;
    early_done = 0;
    stalled    = 1'b0;
    held_d     = '0;
    held_l     = 1'b0;
    first_d    = '0;
    last_d     = '0;
    while (beat < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) early_done++;
      out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 1) || (cyc % 4 == 0));
      if (stalled) begin
        check({name, " valid held"}, out_valid, 1);
        check({name, " data held"}, out_data, held_d);
        check({name, " last held"}, out_last, held_l);
      end
      if (out_valid && out_ready) begin
        check({name, " data"}, out_data, exp_data[beat]);
        check({name, " last"}, out_last, (beat == n - 1));
        if (beat == 0) first_d = out_data;
        last_d  = out_data;
        beat++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held_d  = out_data;
        held_l  = out_last;
      end else begin
        stalled = 1'b0;
      end
    end
    check({name, " beat count"}, beat, n);
    check({name, " no early done"}, early_done, 0);
    @(negedge clk);
    check({name, " done pulse"}, done, 1);
    check({name, " busy low"}, busy, 0);
    @(negedge clk);
    check({name, " done single"}, done, 0);
    check({name, " valid low"}, out_valid, 0);
    out_ready = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [11:0] fd;
    logic [11:0] ld;
    for (int i = 0; i <= int'(v.cap); i++) begin
      exp_data[i] = (v.base + 12'(i)) ^ 12'h800;
    end
    drive_mode1(v.cap, v.base);
    collect(v.name, int'(v.cap) + 1, v.ready_mode, fd, ld);
    check({v.name, " first"}, fd, v.exp_first);
    check({v.name, " last value"}, ld, v.exp_last);
    check({v.name, " overrange"}, overrange, v.exp_ovr);
  endtask

  // Capture a frame with a railed sample and leave its first beat stalled at the port
  task automatic stall_first_beat(input string name);
    int w;
    out_ready = 1'b0;
    drive_mode1(11'd7, 12'hFFC);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({name, " valid seen"}, out_valid, 1);
    repeat (2) @(negedge clk);
    check({name, " stalled data"}, out_data, 12'h7FC);
    check({name, " overrange set"}, overrange, 1);
  endtask

  initial begin
    logic [11:0] m0_seq [13];
    logic [11:0] fd;
    logic [11:0] ld;
    int          n_done;

    vecs[0] = mk("ramp8",  11'd7,    12'h800, 0, 12'h000, 12'h007, 1'b0);
    vecs[1] = mk("bp16",   11'd15,   12'h800, 1, 12'h000, 12'h00F, 1'b0);
    vecs[2] = mk("ovr",    11'd3,    12'hFFD, 0, 12'h7FD, 12'h800, 1'b1);
    vecs[3] = mk("single", 11'd0,    12'h123, 0, 12'h923, 12'h923, 1'b0);
    vecs[4] = mk("neg",    11'd3,    12'h7FC, 1, 12'hFFC, 12'hFFF, 1'b0);
    vecs[5] = mk("full",   11'd2047, 12'h400, 0, 12'hC00, 12'h3FF, 1'b0);

    rst        = 1'b1;
    ad_in      = JUNK;
    arm        = 1'b0;
    abort      = 1'b0;
    trig_mode  = 1'b0;
    trig_level = '0;
    cap_len    = '0;
    out_ready  = 1'b1;

    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset overrange", overrange, 0);
    check("reset done", done, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_last", out_last, 0);
    check("reset out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Immediate-trigger frames from the table
    for (int k = 0; k < 6; k++) begin
      run_vec(vecs[k]);
    end

    // Threshold trigger. Arming above the level, a 0xFFF sample before the
    // trigger, and a first-sample rise must all fail to start the frame.
    m0_seq = '{12'h800, 12'hA00, 12'hA00, 12'hFFF, 12'h980, 12'h840, 12'h7C0,
               12'h800, 12'h8C0, 12'h900, 12'h940, 12'h980, 12'h9C0};
    exp_data[0] = 12'h100;
    exp_data[1] = 12'h140;
    exp_data[2] = 12'h180;
    exp_data[3] = 12'h1C0;
    trig_mode  = 1'b0;
    trig_level = 12'h100;
    cap_len    = 11'd3;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      ad_in = m0_seq[i];
      arm   = (i == 1);
      if (i == 3) check("m0 busy while armed", busy, 1);
      if (i == 5) check("m0 no overrange before trigger", overrange, 0);
    end
    collect("m0", 4, 0, fd, ld);
    check("m0 first", fd, 12'h100);
    check("m0 overrange", overrange, 0);

    // Abort during CAPTURE
    @(negedge clk);
    arm       = 1'b1;
    trig_mode = 1'b1;
    cap_len   = 11'd100;
    @(negedge clk);
    arm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ad_in = 12'h100 + 12'(i);
    end
    check("abcap busy before abort", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abcap busy", busy, 0);
    check("abcap out_valid", out_valid, 0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || out_valid || busy) n_done++;
    end
    check("abcap stays idle", n_done, 0);
    run_vec(vecs[0]);

    // Abort during stalled READOUT. An arm while busy is ignored.
    stall_first_beat("abrd");
    arm     = 1'b1;
    cap_len = 11'd0;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    check("arm ignored busy", busy, 1);
    check("arm ignored data", out_data, 12'h7FC);
    check("arm ignored overrange", overrange, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abrd busy", busy, 0);
    check("abrd out_valid", out_valid, 0);
    check("abrd done", done, 0);
    check("abrd overrange held", overrange, 1);
    @(negedge clk);
    check("abrd no late done", done, 0);
    out_ready = 1'b1;
    run_vec(vecs[0]);

    // Reset during stalled READOUT
    stall_first_beat("rstrd");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstrd busy", busy, 0);
    check("rstrd out_valid", out_valid, 0);
    check("rstrd out_data", out_data, 0);
    check("rstrd out_last", out_last, 0);
    check("rstrd done", done, 0);
    check("rstrd overrange", overrange, 0);
    out_ready = 1'b1;
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
